// File: rtl/fma_dot_seq.sv
// Streaming signed dot-product sequencer: 4-element chunks pass through one
// shared fma_4x4 and their 12-bit sums are accumulated into an ACC_W result.

module fma_4x4 (
    input  logic [15:0] a_vec,
    input  logic [15:0] b_vec,
    output logic [11:0] sum
);
    logic [7:0] prod;

    // Two's-complement products and sums are exact modulo 2^width, so sign
    // extension followed by unsigned arithmetic gives the signed result.
    // NOTE: every variable written in always_comb gets a default first, so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        sum  = '0;
        prod = '0;
        for (int k = 0; k < 4; k++) begin
            prod = {{4{a_vec[4*k+3]}}, a_vec[4*k +: 4]}
                 * {{4{b_vec[4*k+3]}}, b_vec[4*k +: 4]};
            sum  = sum + {{4{prod[7]}}, prod};
        end
    end
endmodule

module fma_dot_seq #(
    parameter int ACC_W = 20,
    parameter int LEN_W = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [LEN_W-1:0]        len,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [15:0]             a_vec,
    input  logic [15:0]             b_vec,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [ACC_W-1:0] result,
    output logic                    busy
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [LEN_W-1:0] remaining;
    logic [11:0]      chunk_sum;
    logic [11:0]      prod_q;
    logic             prod_v;
    logic [ACC_W-1:0] acc;
    logic             handshake;

    fma_4x4 u_fma (
        .a_vec (a_vec),
        .b_vec (b_vec),
        .sum   (chunk_sum)
    );

    assign handshake = in_valid && in_ready;
    assign busy      = (state != IDLE);
    assign result    = acc;

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) state_nxt = (len == '0) ? DONE : RUN;
            end
            RUN: begin
                in_ready = 1'b1;
                if (handshake && remaining == LEN_W'(1)) state_nxt = DRAIN;
            end
            DRAIN: state_nxt = DONE;
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            remaining <= '0;
            prod_q    <= '0;
            prod_v    <= 1'b0;
            acc       <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && start) begin
                acc       <= '0;
                prod_v    <= 1'b0;
                remaining <= len;
            end else begin
                if (prod_v) acc <= acc + {{(ACC_W-12){prod_q[11]}}, prod_q};
                // prod_v only rises on a RUN handshake, so DRAIN retires the last sum.
                prod_v <= handshake;
                if (handshake) begin
                    prod_q    <= chunk_sum;
                    remaining <= remaining - LEN_W'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_fma_dot_seq.sv
// Self-checking bench for fma_dot_seq: table-driven single-chunk jobs plus
// hand-written multi-cycle sequences, with a result scoreboard queue.

module tb_fma_dot_seq;
    localparam int ACC_W    = 20;
    localparam int LEN_W    = 8;
    localparam int MAX_WAIT = 1000;

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic                    start = 1'b0;
    logic [LEN_W-1:0]        len = '0;
    logic                    in_valid = 1'b0;
    logic                    in_ready;
    logic [15:0]             a_vec = '0;
    logic [15:0]             b_vec = '0;
    logic                    out_valid;
    logic                    out_ready = 1'b1;
    logic signed [ACC_W-1:0] result;
    logic                    busy;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   first_ov_cyc = -1;
    logic ov_prev = 1'b0;
    int   exp_q[$];

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        int          expv;
    } vec_t;

    fma_dot_seq #(.ACC_W(ACC_W), .LEN_W(LEN_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .len       (len),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_vec     (a_vec),
        .b_vec     (b_vec),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic signed [31:0] act,
                         input logic signed [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    function automatic int chunk_ref(input logic [15:0] a, input logic [15:0] b);
        int s = 0;
        logic signed [3:0] x;
        logic signed [3:0] y;
        for (int k = 0; k < 4; k++) begin
            x = a[4*k +: 4];
            y = b[4*k +: 4];
            s += int'(x) * int'(y);
        end
        return s;
    endfunction

    // Scoreboard consumer: every result handshake pops one expected value.
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid && !ov_prev) first_ov_cyc = cyc;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_result", 1, 0);
                end else begin
                    int e;
                    e = exp_q.pop_front();
                    check("result", int'(result), e);
                end
            end
        end
        ov_prev = out_valid && rst_n;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_job(input int n, input int expv, output int s_cyc);
        exp_q.push_back(expv);
        first_ov_cyc = -1;
        start = 1'b1;
        len   = n[LEN_W-1:0];
        s_cyc = cyc;
        step();
        start = 1'b0;
    endtask

    task automatic feed_chunk(input logic [15:0] a, input logic [15:0] b, input int gap);
        int n = 0;
        in_valid = 1'b0;
        repeat (gap) step();
        a_vec    = a;
        b_vec    = b;
        in_valid = 1'b1;
        while (!in_ready && n < MAX_WAIT) begin
            step();
            n++;
        end
        if (!in_ready) check("in_ready_timeout", 0, 1);
        step();
        in_valid = 1'b0;
        a_vec    = 16'($urandom);
        b_vec    = 16'($urandom);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy || exp_q.size() != 0) && n < MAX_WAIT) begin
            step();
            n++;
        end
        if (busy || exp_q.size() != 0) check("done_timeout", 0, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t        vt[7];
        int          s;
        int          expv;
        logic [15:0] ra[6];
        logic [15:0] rb[6];

        vt = '{
            '{16'h1111, 16'h1111,    4},
            '{16'hF387, 16'h5288,    9},
            '{16'h8888, 16'h7777, -224},
            '{16'h8888, 16'h8888,  256},
            '{16'h7777, 16'h7777,  196},
            '{16'h0000, 16'hFFFF,    0},
            '{16'h4321, 16'hFFFF,  -10}
        };

        // Reset state
        repeat (3) step();
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_result", int'(result), 0);
        rst_n = 1'b1;
        step();

        // Single-chunk jobs from the table
        foreach (vt[i]) begin
            start_job(1, vt[i].expv, s);
            if (i == 0) check("run_in_ready", in_ready, 1);
            feed_chunk(vt[i].a, vt[i].b, 0);
            wait_idle();
            if (i == 0) begin
                check("len1_latency", first_ov_cyc - s, 3);
                check("len1_busy_after", busy, 0);
            end
        end

        // Two chunks with a 3-cycle bubble: 9 + (-224) = -215 (0xFFF29)
        start_job(2, -215, s);
        feed_chunk(16'hF387, 16'h5288, 0);
        feed_chunk(16'h8888, 16'h7777, 3);
        wait_idle();

        // Longest job, continuous in_valid
        start_job(255, 65280, s);
        for (int i = 0; i < 255; i++) feed_chunk(16'h8888, 16'h8888, 0);
        wait_idle();
        check("len255_latency", first_ov_cyc - s, 257);

        // Random operands and bubbles checked against the reference model
        expv = 0;
        for (int i = 0; i < 6; i++) begin
            ra[i] = 16'($urandom);
            rb[i] = 16'($urandom);
            expv += chunk_ref(ra[i], rb[i]);
        end
        start_job(6, expv, s);
        for (int i = 0; i < 6; i++) feed_chunk(ra[i], rb[i], $urandom_range(0, 2));
        wait_idle();

        // Zero-length job; in_valid pulses must be ignored
        out_ready = 1'b0;
        start_job(0, 0, s);
        a_vec    = 16'h7777;
        b_vec    = 16'h7777;
        in_valid = 1'b1;
        repeat (2) step();
        in_valid = 1'b0;
        step();
        check("len0_out_valid", out_valid, 1);
        check("len0_in_ready", in_ready, 0);
        check("len0_result", int'(result), 0);
        check("len0_latency", first_ov_cyc - s, 1);
        out_ready = 1'b1;
        wait_idle();

        // Backpressure: result held, stray start ignored
        out_ready = 1'b0;
        start_job(1, 196, s);
        feed_chunk(16'h7777, 16'h7777, 0);
        for (int n = 0; n < MAX_WAIT && !out_valid; n++) step();
        for (int i = 0; i < 10; i++) begin
            check("hold_out_valid", out_valid, 1);
            check("hold_result", int'(result), 196);
            start = (i == 4);
            len   = 8'd3;
            step();
        end
        start     = 1'b0;
        out_ready = 1'b1;
        wait_idle();
        repeat (3) step();
        check("stray_start_ignored", busy, 0);
        start_job(1, -10, s);
        feed_chunk(16'h4321, 16'hFFFF, 0);
        wait_idle();

        // Reset in the middle of a 5-chunk job
        start_job(5, 5 * 196, s);
        for (int i = 0; i < 3; i++) feed_chunk(16'h7777, 16'h7777, 0);
        rst_n = 1'b0;
        step();
        check("abort_in_ready", in_ready, 0);
        check("abort_out_valid", out_valid, 0);
        check("abort_busy", busy, 0);
        check("abort_result", int'(result), 0);
        exp_q.delete();
        rst_n = 1'b1;
        step();
        start_job(1, 4, s);
        feed_chunk(16'h1111, 16'h1111, 0);
        wait_idle();
        check("post_abort_latency", first_ov_cyc - s, 3);

        repeat (3) step();
        check("scoreboard_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/fma_dot_seq.md
# fma_dot_seq

Sequencer that computes a signed dot product of arbitrary length by streaming 4-element chunks through a single `fma_4x4` instance and accumulating its 12-bit chunk sums. The shared `fma_4x4` returns the sum of four signed 4-bit × signed 4-bit products. This block owns the handshake, chunk counting, pipeline register and accumulator around it. It sits between a vector source (operand buffer or DMA) and any consumer of the scalar result.

## Interface
- `ACC_W`, default 20: accumulator/result width, signed. Must be ≥ 12 + `LEN_W`.
- `LEN_W`, default 8: width of the chunk-count field. The maximum job is 2^`LEN_W`−1 chunks.

Ports:
- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst_n`  in  1  reset, synchronous and active-low.
- `start`  in  1  job request; sampled only in IDLE.
- `len`  in  `LEN_W`  number of 4-element chunks in the job; latched with `start`.
- `in_valid`  in  1  chunk operands valid.
- `in_ready`  out  1  block accepts a chunk this cycle.
- `a_vec`  in  16  four signed 4-bit elements; element k is bits [4k+3:4k].
- `b_vec`  in  16  four signed 4-bit elements, same packing.
- `out_valid`  out  1  `result` valid.
- `out_ready`  in  1  consumer accepts `result`.
- `result`  out  `ACC_W`  signed dot product.
- `busy`  out  1  high in every state except IDLE.

## Operation
- Datapath: `fma_4x4` inputs are mapped in pairs as (a0,b0), (a1,b1), (a2,b2), (a3,b3). The product of each pair is signed. The 12-bit signed chunk sum is registered into `prod_q`, with a valid flag `prod_v`.
- Accumulator: `acc <= acc + sign_extend(prod_q)` whenever `prod_v`=1. Arithmetic is modulo 2^`ACC_W` with no saturation. Default widths cannot overflow: worst case is 255 × 256 = 65280.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE, with `start`=1 and `len`≠0: latch `len` into `remaining`, clear `acc` and `prod_v`, go to RUN.
  - IDLE, with `start`=1 and `len`=0: clear `acc`, go to DONE, giving result 0.
  - RUN: `in_ready`=1. On a handshake (`in_valid` && `in_ready`), capture the chunk sum and decrement `remaining`. When the handshake consumes the last chunk, go to DRAIN. Otherwise `prod_v` follows the handshake.
  - DRAIN: `in_ready`=0. The final `prod_q` is added to `acc`. Go to DONE.
  - DONE: `out_valid`=1 and `result`=`acc`. Both are held stable until `out_ready`=1, then go to IDLE.
- `start` outside IDLE is ignored and not queued.
- `in_valid` outside RUN is ignored. Operands are don't-care when `in_valid`=0.
- `in_ready` depends only on state, never on `in_valid`.

## Timing
- Reset (`rst_n`=0 at an edge): state=IDLE; `in_ready`=0, `out_valid`=0, `busy`=0, `result`=0; `acc`, `prod_q`, `prod_v` and `remaining` are all 0.
- Reset during RUN, DRAIN or DONE aborts the job. No `out_valid` is produced for it.
- `start` sampled in cycle S gives RUN (`in_ready`=1) in cycle S+1. For `len`=0 it gives `out_valid`=1 in cycle S+1.
- Last chunk handshake in cycle T gives DRAIN in T+1 and `out_valid`=1 in T+2.
- Minimum job latency with no stalls: `start` at S to `out_valid` at S + `len` + 2.
- Throughput: one chunk per cycle while `in_valid`=1. Bubbles on `in_valid` only add cycles and do not change `result`.
- `out_valid` and `out_ready` in the same cycle: result is consumed and the block is in IDLE next cycle. A new `start` is accepted that following cycle at the earliest.
- `out_ready` held low: DONE persists indefinitely and `result` does not change.
- `busy`=1 from the cycle after `start` is accepted through the cycle of the result handshake.

## Test plan
- `len`=1, a=(1,1,1,1), b=(1,1,1,1), `out_ready`=1 → `out_valid` 3 cycles after `start`, `result`=4, then `busy`=0.
- `len`=2. Chunk 0: a=(7,−8,3,−1), b=(−8,−8,2,5), sum 9. Chunk 1: a=(−8,−8,−8,−8), b=(7,7,7,7), sum −224. `in_valid` deasserted for 3 cycles between the chunks → `result`=−215 (20-bit 0xFFF29).
- `len`=255, every element of a and b = −8, continuous `in_valid` → `result`=65280 at `start` + 257 cycles.
- `len`=0 → `out_valid` in `start`+1 with `result`=0. `in_valid` pulses during the job are ignored.
- Backpressure: `out_ready`=0 for 10 cycles in DONE → `result` stable throughout. A `start` pulse in that window is ignored. A later `start` after the handshake runs normally.
- Reset mid-job: `rst_n`=0 for one cycle after 3 of 5 chunks → all outputs 0 and state IDLE. A new `len`=1 job then gives the correct result, with no residue from the aborted job.
